// File: rtl/ascii_hex_parser_pkg.sv
// Shared constants and state encoding for the ASCII hex line parser.
package ascii_hex_parser_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      DISCARD = 2'd2
   } state_t;

   function automatic logic is_term(input logic [7:0] c);
      return (c == ASCII_CR) || (c == ASCII_LF);
   endfunction

endpackage

// File: rtl/ascii_to_nibble.sv
// Combinational ASCII hex-digit decoder; nibble reads zero for non-hex bytes.
module ascii_to_nibble (
   input  logic [7:0] i_ascii,
   output logic [3:0] o_nibble,
   output logic       o_is_hex
);

   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      o_nibble = 4'd0;
      o_is_hex = 1'b0;
      if (i_ascii >= 8'h30 && i_ascii <= 8'h39) begin
         o_is_hex = 1'b1;
         o_nibble = i_ascii[3:0];
      end else if ((i_ascii >= 8'h41 && i_ascii <= 8'h46) ||
                   (i_ascii >= 8'h61 && i_ascii <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so adding 9 gives 10..15.
         o_is_hex = 1'b1;
         o_nibble = i_ascii[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/ascii_hex_parser.sv
// Parses CR/LF-terminated lines of up to N_DIGITS hex digits into a binary value,
// flagging bad characters and overflow once per line.
module ascii_hex_parser
   import ascii_hex_parser_pkg::*;
#(
   parameter  int N_DIGITS = 4,
   localparam int WIDTH    = 4 * N_DIGITS
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   output logic [WIDTH-1:0] o_value,
   output logic             o_valid,
   output logic [3:0]       o_ndigits,
   output logic             o_error
);

   localparam int CNT_W = $clog2(N_DIGITS + 1);

   state_t             state;
   logic [WIDTH-1:0]   acc;
   logic [CNT_W-1:0]   count;
   logic [3:0]         nibble;
   logic               is_hex;
   logic               term;

   ascii_to_nibble u_nibble (
      .i_ascii  (i_rx_data),
      .o_nibble (nibble),
      .o_is_hex (is_hex)
   );

   assign term = is_term(i_rx_data);

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         o_value   <= '0;
         o_ndigits <= '0;
         o_valid   <= 1'b0;
         o_error   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         o_error <= 1'b0;
         if (i_rx_valid) begin
            unique case (state)
               IDLE: begin
                  if (is_hex) begin
                     acc   <= WIDTH'(nibble);
                     count <= CNT_W'(1);
                     state <= ACCUM;
                  end else if (!term) begin
                     o_error <= 1'b1;
                     state   <= DISCARD;
                  end
               end
               ACCUM: begin
                  if (is_hex) begin
                     if (count < CNT_W'(N_DIGITS)) begin
                        acc   <= (acc << 4) | WIDTH'(nibble);
                        count <= count + CNT_W'(1);
                     end else begin
                        o_error <= 1'b1;
                        state   <= DISCARD;
                     end
                  end else if (term) begin
                     o_value   <= acc;
                     o_ndigits <= 4'(count);
                     o_valid   <= 1'b1;
                     acc       <= '0;
                     count     <= '0;
                     state     <= IDLE;
                  end else begin
                     o_error <= 1'b1;
                     state   <= DISCARD;
                  end
               end
               DISCARD: begin
                  // Bad line: stay silent until the terminator resyncs us.
                  if (term) begin
                     acc   <= '0;
                     count <= '0;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed and randomized line stimulus against a line-level reference model.
module tb_ascii_hex_parser;

   localparam int N     = 4;
   localparam int WIDTH = 4 * N;

   logic             clk;
   logic             rst_n;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic [WIDTH-1:0] value;
   logic             valid;
   logic [3:0]       ndigits;
   logic             error;

   int vectors     = 0;
   int miscompares = 0;

   // reference model: digits seen on the current line, and whether it went bad
   int              m_cnt;
   bit              m_bad;
   longint unsigned m_val;
   bit              e_valid;
   bit              e_error;
   longint unsigned e_value;
   int              e_nd;

   ascii_hex_parser #(.N_DIGITS(N)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_rx_data  (rx_data),
      .i_rx_valid (rx_valid),
      .o_value    (value),
      .o_valid    (valid),
      .o_ndigits  (ndigits),
      .o_error    (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int hexval(input logic [7:0] b);
      if (b >= "0" && b <= "9") return int'(b) - int'("0");
      if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
      if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_bad = 0; m_val = 0;
      e_valid = 0; e_error = 0; e_value = 0; e_nd = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      int hv;
      hv = hexval(b);
      e_valid = 0;
      e_error = 0;
      if (b == 8'h0D || b == 8'h0A) begin
         if (!m_bad && m_cnt > 0) begin
            e_valid = 1;
            e_value = m_val;
            e_nd    = m_cnt;
         end
         m_bad = 0; m_cnt = 0; m_val = 0;
      end else if (m_bad) begin
      end else if (hv < 0 || m_cnt == N) begin
         e_error = 1;
         m_bad   = 1;
      end else begin
         m_val = m_val * 16 + longint'(hv);
         m_cnt++;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_valid"},   64'(valid),   64'(e_valid));
      check({tag, "_error"},   64'(error),   64'(e_error));
      check({tag, "_value"},   64'(value),   e_value);
      check({tag, "_ndigits"}, 64'(ndigits), 64'(e_nd));
   endtask

   // Drives a strobe now; the caller has already aligned to a negedge.
   task automatic drive_and_check(input logic [7:0] b, input string tag);
      rx_data  = b;
      rx_valid = 1'b1;
      model_byte(b);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic send(input logic [7:0] b, input string tag);
      @(negedge clk);
      drive_and_check(b, tag);
   endtask

   task automatic send_str(input string s, input string tag);
      for (int i = 0; i < s.len(); i++) send(s[i], tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         e_valid  = 0;
         e_error  = 0;
         @(posedge clk);
         #1;
         check("idle_valid", 64'(valid), 64'd0);
         check("idle_error", 64'(error), 64'd0);
      end
   endtask

   initial begin
      string hexchars;
      hexchars = "0123456789abcdefABCDEF";
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      rst_n    = 1'b0;
      model_reset();

      #12;
      check_outputs("reset");

      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // "1a2F\r\n": single result, trailing LF ignored
      send_str("1a2F\r\n", "crlf");
      // "7\n" then a lone "\n"
      send_str("7\n", "one_digit");
      send_str("\n", "lone_lf");
      // overflow on fifth digit, value retained
      send_str("12345\n", "overflow");
      idle(2);
      // bad character, then a good short line
      send_str("1G3\nAB\n", "bad_char");
      // back-to-back full-width line ending in CR
      send_str("FFFF\r", "full");

      // reset mid-line discards "12"; strobe on first edge after release
      send_str("12", "pre_reset");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      drive_and_check("3", "post_reset");
      send("\n", "post_reset");

      // randomized lines
      for (int line = 0; line < 200; line++) begin
         int len;
         len = $urandom_range(0, 6);
         for (int k = 0; k < len; k++) begin
            int kind;
            logic [7:0] b;
            kind = $urandom_range(0, 9);
            if (kind <= 6) b = hexchars[$urandom_range(0, 21)];
            else           b = 8'($urandom);
            send(b, "rand");
            if ($urandom_range(0, 4) == 0) idle(1);
         end
         case ($urandom_range(0, 2))
            0: send(8'h0D, "rand_term");
            1: send(8'h0A, "rand_term");
            default: begin
               send(8'h0D, "rand_term");
               send(8'h0A, "rand_term");
            end
         endcase
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ascii_hex_parser.md
ASCII_HEX_PARSER -- requirements
Module: ascii_hex_parser

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, giving the maximum hex digits per line (range 1..8).
REQ-002 SHALL have localparam WIDTH = 4*N_DIGITS, giving the output value width.
REQ-003 SHALL have port i_clk, input, 1, the single system clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port i_rx_data, input, 8, the received ASCII byte.
REQ-006 SHALL have port i_rx_valid, input, 1, a one-cycle strobe that qualifies i_rx_data.
REQ-007 SHALL have port o_value, output, WIDTH, the parsed value, right-aligned and zero-extended.
REQ-008 SHALL have port o_valid, output, 1, a one-cycle pulse marking o_value as new.
REQ-009 SHALL have port o_ndigits, output, 4, the digit count of the last good line.
REQ-010 SHALL have port o_error, output, 1, a one-cycle pulse on a bad character or on overflow.

Function
REQ-011 SHALL accept a byte only in a cycle where i_rx_valid=1; bytes are never back-pressured, and back-to-back strobes are legal.
REQ-012 SHALL classify each byte as one of:
  - hex digit: 0x30-0x39, 0x41-0x46, 0x61-0x66 (case-insensitive);
  - terminator: CR 0x0D or LF 0x0A;
  - other: every remaining value.
REQ-013 SHALL implement the states IDLE, ACCUM and DISCARD.
REQ-014 IDLE transitions:
  - hex digit -> acc = nibble, count = 1, go to ACCUM;
  - terminator -> ignore, stay in IDLE (so CRLF yields one result);
  - other -> pulse o_error, go to DISCARD.
REQ-015 ACCUM transitions:
  - hex digit with count < N_DIGITS -> acc = {acc[WIDTH-5:0], nibble}, count++;
  - hex digit with count = N_DIGITS -> pulse o_error (overflow), go to DISCARD;
  - terminator -> load o_value = acc, o_ndigits = count, pulse o_valid, go to IDLE;
  - other -> pulse o_error, go to DISCARD.
REQ-016 DISCARD SHALL ignore every byte except a terminator, which returns the block to IDLE with no o_valid pulse.
REQ-017 o_valid and o_error SHALL be registered and SHALL assert in the cycle after the strobe that causes them.
REQ-018 o_valid and o_error SHALL never assert in the same cycle, and each SHALL be exactly one cycle wide.
REQ-019 o_value and o_ndigits SHALL hold their values until the next good line.
REQ-020 A line with fewer than N_DIGITS digits SHALL be zero-extended in the upper bits (e.g. "1F" gives 0x001F).
REQ-021 The accumulator and count SHALL clear whenever IDLE is entered.
REQ-022 Only one error pulse SHALL be issued per bad line; bytes received in DISCARD raise no further errors.

Reset
REQ-023 Asserting i_rst_n=0 SHALL immediately set state=IDLE, acc=0, count=0, o_value=0, o_ndigits=0, o_valid=0 and o_error=0.
REQ-024 Reset asserted mid-line SHALL discard the partial line; the first byte after release is treated as line start.
REQ-025 A strobe coincident with the first clock edge after reset release SHALL be processed normally.

Structure
REQ-026 A shared package SHALL hold the constants ASCII_CR=8'h0D and ASCII_LF=8'h0A and the state encoding (2 bits: IDLE=0, ACCUM=1, DISCARD=2).
REQ-027 The block SHALL instantiate one combinational sub-module, ascii_to_nibble:
  - inputs: i_ascii[7:0];
  - outputs: o_nibble[3:0] and o_is_hex;
  - o_nibble=0 when o_is_hex=0.
REQ-028 Digit count and accumulator SHALL be registers, sized to hold N_DIGITS.

Verification
REQ-029 Stream "1a2F\r\n" (N_DIGITS=4) -> one o_valid pulse with o_value=0x1A2F and o_ndigits=4, no o_error, and the trailing LF is ignored.
REQ-030 Stream "7\n" -> o_value=0x0007, o_ndigits=1; then "\n" alone -> no pulse of any kind.
REQ-031 Stream "12345\n" -> o_error pulse one cycle after the '5' strobe, no o_valid, and o_value keeps its previous value.
REQ-032 Stream "1G3\nAB\n" -> o_error after 'G', no output for the first line, then o_valid with 0x00AB.
REQ-033 Drop i_rst_n after "12", release, then send "3\n" -> o_value=0x0003, and all outputs read 0 during reset.
REQ-034 Stream "FFFF\r" with i_rx_valid high on consecutive cycles -> o_valid exactly one cycle after the CR strobe, with o_value=0xFFFF.
